// File: rtl/jhash_feeder.sv
// jhash_feeder: producer side of the jhash key stream.
// Packs a key, supplied as 32-bit words, into 3-word groups and presents each
// group to jhash_core on a valid/ack handshake. The final group carries
// stream_done/stream_left. After every ack, a gap counter holds off the next
// presentation until the core has finished mixing the previous group.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start, key_len    begin a new key of key_len words (sampled only when idle)
//   word_in/valid     key word source
//   word_ready        feeder takes word_in this cycle
//   stream_data0..2   presented group
//   stream_valid      group presented, held until stream_ack
//   stream_ack        core consumed the group
//   stream_done       presented/last group is the final one
//   stream_left       valid words in the final group (0..3)
//   hash_done         core finished the key
//   busy              key in progress
module jhash_feeder #(
    parameter int unsigned LEN_W      = 16,
    parameter int unsigned RUN_CYCLES = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] key_len,
    input  logic [31:0]      word_in,
    input  logic             word_valid,
    output logic             word_ready,
    output logic [31:0]      stream_data0,
    output logic [31:0]      stream_data1,
    output logic [31:0]      stream_data2,
    output logic             stream_valid,
    input  logic             stream_ack,
    output logic             stream_done,
    output logic [1:0]       stream_left,
    input  logic             hash_done,
    output logic             busy
);

    localparam int unsigned CNT_W = (RUN_CYCLES < 1) ? 1 : $clog2(RUN_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        GAP,
        PRESENT,
        WAIT_HASH
    } state_t;

    state_t           state, state_n;
    logic [LEN_W-1:0] remaining, remaining_n;
    logic [1:0]       idx, idx_n;
    logic             last_grp, last_grp_n;
    logic [1:0]       left, left_n;
    logic [CNT_W-1:0] gap_cnt, gap_cnt_n;

    logic             word_ready_n;
    logic [31:0]      data0_n, data1_n, data2_n;
    logic             stream_valid_n;
    logic             stream_done_n;
    logic [1:0]       stream_left_n;
    logic             busy_n;

    logic             xfer;

    assign xfer = word_valid && word_ready;

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            remaining    <= '0;
            idx          <= '0;
            last_grp     <= 1'b0;
            left         <= '0;
            gap_cnt      <= '0;
            word_ready   <= 1'b0;
            stream_data0 <= '0;
            stream_data1 <= '0;
            stream_data2 <= '0;
            stream_valid <= 1'b0;
            stream_done  <= 1'b0;
            stream_left  <= '0;
            busy         <= 1'b0;
        end else begin
            state        <= state_n;
            remaining    <= remaining_n;
            idx          <= idx_n;
            last_grp     <= last_grp_n;
            left         <= left_n;
            gap_cnt      <= gap_cnt_n;
            word_ready   <= word_ready_n;
            stream_data0 <= data0_n;
            stream_data1 <= data1_n;
            stream_data2 <= data2_n;
            stream_valid <= stream_valid_n;
            stream_done  <= stream_done_n;
            stream_left  <= stream_left_n;
            busy         <= busy_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n        = state;
        remaining_n    = remaining;
        idx_n          = idx;
        last_grp_n     = last_grp;
        left_n         = left;
        word_ready_n   = word_ready;
        data0_n        = stream_data0;
        data1_n        = stream_data1;
        data2_n        = stream_data2;
        stream_valid_n = stream_valid;
        stream_done_n  = stream_done;
        stream_left_n  = stream_left;
        busy_n         = busy;
        // Gap counter free-runs down to zero in every state; reloaded on ack.
        gap_cnt_n      = (gap_cnt != '0) ? gap_cnt - CNT_W'(1) : gap_cnt;

        unique case (state)
            IDLE: begin
                if (start) begin
                    remaining_n = key_len;
                    idx_n       = '0;
                    data0_n     = '0;
                    data1_n     = '0;
                    data2_n     = '0;
                    busy_n      = 1'b1;
                    left_n      = '0;
                    if (key_len == '0) begin
                        // Empty key: one all-zero final group.
                        last_grp_n = 1'b1;
                        state_n    = GAP;
                    end else begin
                        last_grp_n   = 1'b0;
                        word_ready_n = 1'b1;
                        state_n      = FILL;
                    end
                end
            end

            FILL: begin
                if (xfer) begin
                    unique case (idx)
                        2'd0:    data0_n = word_in;
                        2'd1:    data1_n = word_in;
                        default: data2_n = word_in;
                    endcase
                    idx_n = idx + 2'd1;
                    if (remaining != '0) begin
                        remaining_n = remaining - LEN_W'(1);
                    end
                    if (remaining <= LEN_W'(1)) begin
                        // Last word of the key closes the final group.
                        last_grp_n   = 1'b1;
                        left_n       = idx + 2'd1;
                        word_ready_n = 1'b0;
                        state_n      = GAP;
                    end else if (idx == 2'd2) begin
                        last_grp_n   = 1'b0;
                        left_n       = 2'd3;
                        word_ready_n = 1'b0;
                        state_n      = GAP;
                    end
                end
            end

            GAP: begin
                if (gap_cnt == '0) begin
                    stream_valid_n = 1'b1;
                    stream_done_n  = last_grp;
                    stream_left_n  = last_grp ? left : 2'd0;
                    state_n        = PRESENT;
                end
            end

            PRESENT: begin
                if (stream_ack) begin
                    stream_valid_n = 1'b0;
                    gap_cnt_n      = CNT_W'(RUN_CYCLES);
                    if (last_grp) begin
                        state_n = WAIT_HASH;
                    end else begin
                        data0_n      = '0;
                        data1_n      = '0;
                        data2_n      = '0;
                        idx_n        = '0;
                        word_ready_n = 1'b1;
                        state_n      = FILL;
                    end
                end
            end

            WAIT_HASH: begin
                if (hash_done) begin
                    stream_done_n = 1'b0;
                    stream_left_n = '0;
                    data0_n       = '0;
                    data1_n       = '0;
                    data2_n       = '0;
                    busy_n        = 1'b0;
                    last_grp_n    = 1'b0;
                    left_n        = '0;
                    state_n       = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: doc/jhash_feeder.md
Name: jhash_feeder

Overview:
- Producer end of the jhash key stream: accepts a key as a sequence of 32-bit words and packs them into 3-word groups (stream_data0/1/2).
- Presents each group to jhash_core over the stream_valid/stream_ack handshake, with stream_done/stream_left marking the final group.
- Sits between the key source (DMA/register FIFO) and jhash_core.
- Enforces the core's timing rule: stream_done is never visible while the core is still mixing the previous group.

Parameters:
LEN_W, 16, width of key length in 32-bit words
RUN_CYCLES, 6, minimum cycles from a stream_ack to the next group's stream_valid/stream_done (core mix duration)

Ports:
clk  input  1  clock
rst  input  1  reset
start  input  1  one-cycle pulse; begin a new key; sampled only in IDLE
key_len  input  LEN_W  key length in words, latched on start
word_in  input  32  key word
word_valid  input  1  word_in valid
word_ready  output  1  feeder accepts word_in this cycle
stream_data0  output  32  group word 0
stream_data1  output  32  group word 1
stream_data2  output  32  group word 2
stream_valid  output  1  group presented
stream_ack  input  1  core consumed the group
stream_done  output  1  presented/last group is final
stream_left  output  2  valid words in the final group (0..3)
hash_done  input  1  core finished
busy  output  1  high from start until return to IDLE

Behaviour:
- Interface: reset rst, asynchronous, active-high; clock clk.
- Reset value of every output is 0. Internal state returns to IDLE. Reset mid-operation discards the partial key.
- All outputs are registered. Word transfer occurs when word_valid && word_ready.
- State machine: IDLE, FILL, GAP, PRESENT, WAIT_HASH.
- IDLE:
  - On start, latch remaining = key_len, clear the buffer and slot index, and set busy = 1.
  - If key_len == 0, go to GAP with final = 1 and left = 0.
  - Otherwise go to FILL.
  - start in any other state is ignored.
- FILL:
  - word_ready = 1. Each transfer writes slot idx (0, 1, 2), then idx++ and remaining--.
  - When idx reaches 3, or remaining reaches 0 on that transfer, go to GAP. word_ready drops the following cycle.
  - final = 1 when remaining after the transfer is 0 (only possible in the final group). left = idx after the transfer.
  - Non-final groups are always full: left = 3, done = 0.
  - Slots not written are 0.
- GAP:
  - Wait until the gap counter (loaded with RUN_CYCLES on every stream_ack, decremented to 0) is 0, then go to PRESENT.
  - The first group has no preceding ack, so the counter is 0 and GAP lasts exactly 1 cycle.
- PRESENT:
  - stream_valid = 1. stream_done = final. stream_left = left if final, else 0.
  - Data, done and left are held stable until stream_ack.
  - On stream_ack, stream_valid drops next cycle and the gap counter loads RUN_CYCLES.
  - If final, go to WAIT_HASH. Otherwise clear the buffer, set idx = 0, and go to FILL.
  - stream_ack while not in PRESENT is ignored.
- WAIT_HASH:
  - stream_valid = 0. stream_done and stream_left are held.
  - On hash_done, clear stream_done, stream_left, data and busy, and go to IDLE.
- Boundary conditions:
  - key_len a multiple of 3: the final group has left = 3, done = 1.
  - key_len = 0: a single all-zero group with left = 0, done = 1.
  - remaining is never decremented below 0. Extra word_valid after the final word is not accepted.

Test Plan:
- key_len=0 -> one group, data 0/0/0, stream_left=0, stream_done=1; after hash_done: busy=0, all stream outputs 0.
- key_len=3, words 1,2,3 back-to-back, ack immediate -> one group 1/2/3, left=3, done=1; word_ready low after the 3rd word.
- key_len=4, words 0xA..0xD -> group A/B/C done=0, left=0. After ack, the next group (D/0/0, left=1, done=1) does not raise stream_valid for 6 cycles after the ack.
- key_len=7, word_valid toggling every other cycle, ack held off 5 cycles -> groups (w0-w2), (w3-w5), (w6,0,0 left=1 done=1); data and done stable while unacked.
- Reset asserted mid-FILL with 2 of 3 words loaded -> all outputs 0 immediately; next start with key_len=2 produces only the new words (left=2).
- start pulsed during PRESENT with a different key_len -> ignored; the original sequence completes unchanged.
